joystick_cmd_sched: RTL and testbench

- Turns debounced joystick levels from two players into discrete game commands.
- Per player: direction press events, auto-repeat while a direction is held, and fire edges with a cooldown.
- Round-robin arbiter shares one valid/ready command channel between the two players.
- Sits between the per-player debounce stage and the game-logic FSM.

---
 rtl/joystick_cmd_sched_pkg.sv | 26 ++
 rtl/joystick_cmd_sched_if.sv | 35 +++
 rtl/joystick_event_gen.sv | 133 +++++++++++++
 rtl/joystick_cmd_sched.sv | 104 ++++++++++
 tb/tb_joystick_cmd_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/joystick_cmd_sched_pkg.sv
// ============================================================================
// Module      : joystick_pkg
// Description : Shared direction encoding and command record for the
//               joystick command scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package joystick_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef logic [3:0] dir_t;

    typedef struct packed {
        logic player;
        dir_t dir;
        logic fire;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/joystick_cmd_sched_if.sv
// ============================================================================
// Module      : joystick_cmd_sched_if
// Description : valid/ready command channel from the scheduler to game logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface joystick_cmd_sched_if;
    import joystick_pkg::*;

    logic o_cmd_valid;
    logic i_cmd_ready;
    logic o_cmd_player;
    dir_t o_cmd_dir;
    logic o_cmd_fire;

    modport master (
        output o_cmd_valid,
        output o_cmd_player,
        output o_cmd_dir,
        output o_cmd_fire,
        input  i_cmd_ready
    );

    modport slave (
        input  o_cmd_valid,
        input  o_cmd_player,
        input  o_cmd_dir,
        input  o_cmd_fire,
        output i_cmd_ready
    );

endinterface

`default_nettype wire

// File: rtl/joystick_event_gen.sv
// ============================================================================
// Module      : joystick_event_gen
// Description : Per-player direction resolve, auto-repeat, fire cooldown and
//               single pending command slot. JOY_DIAG_EN enables diagonals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joystick_event_gen
    import joystick_pkg::*;
#(
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int FIRE_COOLDOWN = 15000000,
    parameter int CNT_W         = 24
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire dir_t i_dir,
    input  wire logic i_fire,
    input  wire logic i_take,
    output dir_t      o_slot_dir,
    output logic      o_slot_fire,
    output logic      o_pend,
    output logic      o_overrun
);

    localparam logic [CNT_W-1:0] C_DELAY_LD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_PERIOD_LD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_COOL_LD   = CNT_W'(FIRE_COOLDOWN);

    dir_t             prev_dir_q, prev_dir_d;
    logic             prev_fire_q;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic             pend_q, pend_d;
    dir_t             slot_dir_q, slot_dir_d;
    logic             slot_fire_q, slot_fire_d;
    logic             overrun_q, overrun_d;

    dir_t w_res;
    logic w_dir_evt;
    logic w_fire_evt;

    always_comb begin
        w_res = '0;
`ifdef JOY_DIAG_EN
        if (i_dir[DIR_UP])         w_res[DIR_UP]    = 1'b1;
        else if (i_dir[DIR_DOWN])  w_res[DIR_DOWN]  = 1'b1;
        if (i_dir[DIR_LEFT])       w_res[DIR_LEFT]  = 1'b1;
        else if (i_dir[DIR_RIGHT]) w_res[DIR_RIGHT] = 1'b1;
`else
        if (i_dir[DIR_UP])         w_res[DIR_UP]    = 1'b1;
        else if (i_dir[DIR_DOWN])  w_res[DIR_DOWN]  = 1'b1;
        else if (i_dir[DIR_LEFT])  w_res[DIR_LEFT]  = 1'b1;
        else if (i_dir[DIR_RIGHT]) w_res[DIR_RIGHT] = 1'b1;
`endif
    end

    always_comb begin
        prev_dir_d = w_res;
        rpt_cnt_d  = rpt_cnt_q;
        w_dir_evt  = 1'b0;
        if (w_res == '0) begin
            rpt_cnt_d = '0;
        end else if (w_res != prev_dir_q) begin
            w_dir_evt = 1'b1;
            rpt_cnt_d = C_DELAY_LD;
        end else if (rpt_cnt_q == '0) begin
            w_dir_evt = 1'b1;
            rpt_cnt_d = C_PERIOD_LD;
        end else begin
            rpt_cnt_d = rpt_cnt_q - 1'b1;
        end

        w_fire_evt = 1'b0;
        cool_d     = cool_q;
        if (i_fire && !prev_fire_q && cool_q == '0) begin
            w_fire_evt = 1'b1;
            cool_d     = C_COOL_LD;
        end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end

        // A slot being handed to the arbiter this cycle counts as empty,
        // so a new event refills it instead of merging.
        pend_d      = pend_q & ~i_take;
        slot_dir_d  = slot_dir_q;
        slot_fire_d = slot_fire_q;
        overrun_d   = 1'b0;
        if (w_dir_evt || w_fire_evt) begin
            if (pend_q && !i_take) begin
                overrun_d   = 1'b1;
                slot_fire_d = slot_fire_q | w_fire_evt;
                if (w_dir_evt) slot_dir_d = w_res;
            end else begin
                pend_d      = 1'b1;
                slot_dir_d  = w_dir_evt ? w_res : '0;
                slot_fire_d = w_fire_evt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dir_q  <= '0;
            prev_fire_q <= 1'b0;
            rpt_cnt_q   <= '0;
            cool_q      <= '0;
            pend_q      <= 1'b0;
            slot_dir_q  <= '0;
            slot_fire_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_dir_q  <= prev_dir_d;
            prev_fire_q <= i_fire;
            rpt_cnt_q   <= rpt_cnt_d;
            cool_q      <= cool_d;
            pend_q      <= pend_d;
            slot_dir_q  <= slot_dir_d;
            slot_fire_q <= slot_fire_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_slot_dir  = slot_dir_q;
    assign o_slot_fire = slot_fire_q;
    assign o_pend      = pend_q;
    assign o_overrun   = overrun_q;

endmodule

`default_nettype wire

// File: rtl/joystick_cmd_sched.sv
// ============================================================================
// Module      : joystick_cmd_sched
// Description : Two-player joystick command scheduler with round-robin
//               arbitration onto one valid/ready channel. JOY_DIAG_EN enables
//               diagonal directions in the per-player event generators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joystick_cmd_sched
    import joystick_pkg::*;
#(
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int FIRE_COOLDOWN = 15000000,
    parameter int CNT_W         = 24
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire dir_t              i_p0_dir,
    input  wire logic              i_p0_fire,
    input  wire dir_t              i_p1_dir,
    input  wire logic              i_p1_fire,
    joystick_cmd_sched_if.master   cmd_if,
    output logic [1:0]             o_overrun
);

    dir_t       w_dir_in   [2];
    logic [1:0] w_fire_in;
    dir_t       w_slot_dir [2];
    logic [1:0] w_slot_fire;
    logic [1:0] w_pend;
    logic [1:0] w_take;
    logic       w_grant;
    logic       w_load;

    logic valid_q, valid_d;
    cmd_t cmd_q, cmd_d;
    logic ptr_q, ptr_d;

    assign w_dir_in[0] = i_p0_dir;
    assign w_dir_in[1] = i_p1_dir;
    assign w_fire_in   = {i_p1_fire, i_p0_fire};

    for (genvar p = 0; p < 2; p++) begin : g_player
        joystick_event_gen #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .FIRE_COOLDOWN (FIRE_COOLDOWN),
            .CNT_W         (CNT_W)
        ) u_event_gen (
            .clk         (clk),
            .rst         (rst),
            .i_dir       (w_dir_in[p]),
            .i_fire      (w_fire_in[p]),
            .i_take      (w_take[p]),
            .o_slot_dir  (w_slot_dir[p]),
            .o_slot_fire (w_slot_fire[p]),
            .o_pend      (w_pend[p]),
            .o_overrun   (o_overrun[p])
        );
    end

    // The pointer remembers the last grantee; with both pending the other
    // player wins, which yields strict alternation under contention.
    always_comb begin
        w_grant = (&w_pend) ? ~ptr_q : w_pend[1];
        w_load  = (~valid_q | cmd_if.i_cmd_ready) & (|w_pend);
        w_take  = '0;
        valid_d = valid_q;
        cmd_d   = cmd_q;
        ptr_d   = ptr_q;
        if (w_load) begin
            w_take[w_grant] = 1'b1;
            valid_d         = 1'b1;
            cmd_d.player    = w_grant;
            cmd_d.dir       = w_slot_dir[w_grant];
            cmd_d.fire      = w_slot_fire[w_grant];
            ptr_d           = w_grant;
        end else if (cmd_if.i_cmd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
            ptr_q   <= 1'b1;
        end else begin
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cmd_if.o_cmd_valid  = valid_q;
    assign cmd_if.o_cmd_player = cmd_q.player;
    assign cmd_if.o_cmd_dir    = cmd_q.dir;
    assign cmd_if.o_cmd_fire   = cmd_q.fire;

endmodule

`default_nettype wire

// File: tb/tb_joystick_cmd_sched.sv
// ============================================================================
// Module      : tb_joystick_cmd_sched
// Description : Directed self-checking bench for joystick_cmd_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_joystick_cmd_sched;
    import joystick_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    dir_t       p0_dir = '0;
    logic       p0_fire = 1'b0;
    dir_t       p1_dir = '0;
    logic       p1_fire = 1'b0;
    logic [1:0] overrun;

    int n_pass  = 0;
    int n_total = 0;

    joystick_cmd_sched_if cmd_if();

    joystick_cmd_sched #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .FIRE_COOLDOWN (6),
        .CNT_W         (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_p0_dir  (p0_dir),
        .i_p0_fire (p0_fire),
        .i_p1_dir  (p1_dir),
        .i_p1_fire (p1_fire),
        .cmd_if    (cmd_if),
        .o_overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        p0_dir = '0; p0_fire = 1'b0; p1_dir = '0; p1_fire = 1'b0;
        cmd_if.i_cmd_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire, overrun} !== 9'd0)
                $display("FAIL reset_idle cyc%0d: got v=%0b p=%0b d=%b f=%0b ovr=%b, want all 0", k,
                         cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire, overrun);
            else n_pass++;
            tick();
        end
    endtask

    // Single-cycle taps: latency n+2, then resolve priority cases.
    task automatic test_tap;
        dir_t taps [4] = '{4'b1000, 4'b1001, 4'b1100, 4'b0110};
        dir_t exps [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100};
        for (int t = 0; t < 4; t++) begin
            do_reset();
            p0_dir = taps[t];
            tick();
            p0_dir = '0;
            n_total++;
            if (cmd_if.o_cmd_valid !== 1'b0)
                $display("FAIL tap%0d_early: valid=%0b at n+1, want 0", t, cmd_if.o_cmd_valid);
            else n_pass++;
            tick();
            n_total++;
            if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire} !== {1'b1, 1'b0, exps[t], 1'b0})
                $display("FAIL tap%0d_cmd: got v=%0b p=%0b d=%b f=%0b, want v=1 p=0 d=%b f=0", t,
                         cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire, exps[t]);
            else n_pass++;
            tick();
            n_total++;
            if (cmd_if.o_cmd_valid !== 1'b0)
                $display("FAIL tap%0d_drop: valid=%0b after accept, want 0", t, cmd_if.o_cmd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_repeat;
        logic exp_v;
        do_reset();
        p1_dir = 4'b0010;
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_v = (k == 2) || (k == 10) || (k == 14) || (k == 18);
            n_total++;
            if (cmd_if.o_cmd_valid !== exp_v)
                $display("FAIL repeat_valid cyc%0d: got %0b, want %0b", k, cmd_if.o_cmd_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_total++;
                if ({cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire} !== {1'b1, 4'b0010, 1'b0})
                    $display("FAIL repeat_cmd cyc%0d: got p=%0b d=%b f=%0b, want p=1 d=0010 f=0", k,
                             cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire);
                else n_pass++;
            end
            if (k == 19) p1_dir = '0;
        end
    endtask

    task automatic test_fire_cooldown;
        logic exp_v;
        do_reset();
        p0_fire = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            p0_fire = (k == 3) || (k == 7);
            exp_v = (k == 2) || (k == 9);
            n_total++;
            if (cmd_if.o_cmd_valid !== exp_v)
                $display("FAIL fire_valid cyc%0d: got %0b, want %0b", k, cmd_if.o_cmd_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_total++;
                if ({cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire} !== {1'b0, 4'b0000, 1'b1})
                    $display("FAIL fire_cmd cyc%0d: got p=%0b d=%b f=%0b, want p=0 d=0000 f=1", k,
                             cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire);
                else n_pass++;
            end
        end
    endtask

    // Two rounds of simultaneous events: winners go p0,p1,p0,p1 back to back.
    task automatic test_back_to_back;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            p0_dir = 4'b0001; p1_dir = 4'b0100;
            tick();
            p0_dir = '0; p1_dir = '0;
            tick();
            n_total++;
            if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir} !== {1'b1, 1'b0, 4'b0001})
                $display("FAIL rr%0d_first: got v=%0b p=%0b d=%b, want v=1 p=0 d=0001", r,
                         cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir);
            else n_pass++;
            tick();
            n_total++;
            if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir} !== {1'b1, 1'b1, 4'b0100})
                $display("FAIL rr%0d_second: got v=%0b p=%0b d=%b, want v=1 p=1 d=0100", r,
                         cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir);
            else n_pass++;
            tick();
            n_total++;
            if (cmd_if.o_cmd_valid !== 1'b0)
                $display("FAIL rr%0d_idle: valid=%0b, want 0", r, cmd_if.o_cmd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] exp_ovr;
        do_reset();
        cmd_if.i_cmd_ready = 1'b0;
        p0_dir = 4'b1000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            p0_dir  = (k == 3) ? 4'b0100 : (k == 6) ? 4'b0010 : 4'b0000;
            p0_fire = (k == 6);
            exp_ovr = (k == 7) ? 2'b01 : 2'b00;
            n_total++;
            if (overrun !== exp_ovr)
                $display("FAIL bp_overrun cyc%0d: got %b, want %b", k, overrun, exp_ovr);
            else n_pass++;
            if (k >= 2) begin
                n_total++;
                if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire} !== {1'b1, 1'b0, 4'b1000, 1'b0})
                    $display("FAIL bp_hold cyc%0d: got v=%0b p=%0b d=%b f=%0b, want v=1 p=0 d=1000 f=0", k,
                             cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire);
                else n_pass++;
            end
        end
        cmd_if.i_cmd_ready = 1'b1;
        tick();
        n_total++;
        if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire} !== {1'b1, 1'b0, 4'b0010, 1'b1})
            $display("FAIL bp_merged: got v=%0b p=%0b d=%b f=%0b, want v=1 p=0 d=0010 f=1",
                     cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir, cmd_if.o_cmd_fire);
        else n_pass++;
        tick();
        n_total++;
        if (cmd_if.o_cmd_valid !== 1'b0)
            $display("FAIL bp_drain: valid=%0b, want 0", cmd_if.o_cmd_valid);
        else n_pass++;

        // Reset while a command waits drops it at that edge.
        cmd_if.i_cmd_ready = 1'b0;
        p1_dir = 4'b0001;
        tick();
        p1_dir = '0;
        tick();
        n_total++;
        if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player} !== 2'b11)
            $display("FAIL rst_mid_pre: got v=%0b p=%0b, want v=1 p=1", cmd_if.o_cmd_valid, cmd_if.o_cmd_player);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir} !== 6'd0)
            $display("FAIL rst_mid: got v=%0b p=%0b d=%b, want all 0",
                     cmd_if.o_cmd_valid, cmd_if.o_cmd_player, cmd_if.o_cmd_dir);
        else n_pass++;
        cmd_if.i_cmd_ready = 1'b1;
    endtask

    initial begin
        cmd_if.i_cmd_ready = 1'b1;
        test_reset();
        test_tap();
        test_repeat();
        test_fire_cooldown();
        test_back_to_back();
        test_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
